// File: rtl/nios2_system_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_pkg
//  Description : Shared constants and types for the sysid arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios2_system_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int SYSID_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ADDR = ST_ADDR,
        S_DONE = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nios2_system_sysid_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_sysid_arbiter_if
//  Description : Requester-side and sysid-side Avalon-MM read signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios2_system_sysid_arbiter_if
    import nios2_system_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = SYSID_DATA_W
);
    logic [N_REQ-1:0]        m_read;
    logic [N_REQ*ADDR_W-1:0] m_address;
    logic [N_REQ-1:0]        m_waitrequest;
    logic [DATA_W-1:0]       m_readdata;
    logic [ADDR_W-1:0]       s_address;
    logic [DATA_W-1:0]       s_readdata;

    // Arbiter view: slave to the requesters, master to the sysid resource
    modport slave (
        input  m_read, m_address, s_readdata,
        output m_waitrequest, m_readdata, s_address
    );

    modport master (
        output m_read, m_address, s_readdata,
        input  m_waitrequest, m_readdata, s_address
    );
endinterface
`default_nettype wire

// File: rtl/nios2_system_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_rr_arbiter
//  Description : Combinational round-robin pick, first requester after last.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_system_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] last_gnt,
    output logic      [N_REQ-1:0] gnt,
    output logic      [IDX_W-1:0] gnt_idx,
    output logic                  valid
);

    always_comb begin
        int cand;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = 0;
        // Scan offsets 1..N_REQ so last_gnt itself is considered last
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_gnt) + k) % N_REQ;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_system_sysid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_system_sysid_arbiter
//  Description : Round-robin sharing of the sysid slave among N_REQ masters.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_system_sysid_arbiter
    import nios2_system_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = SYSID_DATA_W
) (
    input  wire logic                     clock,
    input  wire logic                     reset_n,
    nios2_system_sysid_arbiter_if.slave   bus,
    output logic                          busy
);

    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  last_gnt;
    logic [ADDR_W-1:0] s_address_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] rd_q;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [N_REQ-1:0]  waitreq;

    nios2_system_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req      (bus.m_read),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .valid    (arb_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) sel_addr = bus.m_address[i*ADDR_W +: ADDR_W];
        end
    end

    // last_gnt doubles as the index of the transaction in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            last_gnt    <= LAST_RST;
            s_address_q <= '0;
            rd_q        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        s_address_q <= sel_addr;
                        last_gnt    <= arb_idx;
                    end
                end
                S_ADDR:  rd_q <= bus.s_readdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        waitreq   = '1;
        case (state)
            S_IDLE:  if (arb_valid) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_DONE;
            S_DONE: begin
                waitreq[last_gnt] = 1'b0;
                state_nxt         = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.m_waitrequest = waitreq;
    assign bus.m_readdata    = rd_q;
    assign bus.s_address     = s_address_q;
    assign busy              = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_sysid_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_system_sysid_arbiter
//  Description : Directed self-checking bench, sysid slave behind 2 masters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_system_sysid_arbiter;
    import nios2_system_pkg::*;

    localparam logic [31:0] TS_VAL = 32'h6089_4570;
    localparam logic [31:0] ID_VAL = 32'h0000_0000;

    logic clock;
    logic reset_n;
    logic busy;
    int   n_checks;
    int   n_fail;

    nios2_system_sysid_arbiter_if #(.N_REQ(2), .ADDR_W(1), .DATA_W(32)) bus ();

    nios2_system_sysid_arbiter #(.N_REQ(2), .ADDR_W(1), .DATA_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    // sysid slave: address 0 = ID, address 1 = timestamp
    assign bus.s_readdata = (bus.s_address == SYSID_ADDR_TS) ? TS_VAL : ID_VAL;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Leaves the bench at a falling edge with the arbiter idle and pointer reset
    task automatic do_reset();
        @(negedge clock);
        reset_n       = 1'b0;
        bus.m_read    = 2'b00;
        bus.m_address = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.m_read    = 2'b00;
        bus.m_address = 2'b00;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL reset_waitreq got=%b exp=11", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0", bus.m_readdata); end
        n_checks++; if (bus.s_address !== 1'b0) begin n_fail++; $display("FAIL reset_saddr got=%b exp=0", bus.s_address); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        bus.m_read    = 2'b01;
        bus.m_address = 2'b01;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL single_addr_wr got=%b exp=11", bus.m_waitrequest); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL single_done_wr got=%b exp=10", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== TS_VAL) begin n_fail++; $display("FAIL single_data got=%h exp=%h", bus.m_readdata, TS_VAL); end
        bus.m_read = 2'b00;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL single_after_wr got=%b exp=11", bus.m_waitrequest); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_after_busy got=%b exp=0", busy); end
        n_checks++; if (bus.m_readdata !== TS_VAL) begin n_fail++; $display("FAIL single_hold_data got=%h exp=%h", bus.m_readdata, TS_VAL); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_wr;
        logic [31:0] exp_d;
        do_reset();
        bus.m_read    = 2'b11;
        bus.m_address = 2'b10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            exp_wr = 2'b11;
            exp_d  = ID_VAL;
            if (i % 3 == 2) begin
                exp_wr = (((i - 2) / 3) % 2 == 0) ? 2'b10 : 2'b01;
                exp_d  = (((i - 2) / 3) % 2 == 0) ? ID_VAL : TS_VAL;
            end
            n_checks++; if (bus.m_waitrequest !== exp_wr) begin n_fail++; $display("FAIL rr_wr cyc=%0d got=%b exp=%b", i, bus.m_waitrequest, exp_wr); end
            if (i % 3 == 2) begin
                n_checks++; if (bus.m_readdata !== exp_d) begin n_fail++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", i, bus.m_readdata, exp_d); end
            end
        end
        bus.m_read = 2'b00;
    endtask

    task automatic test_staggered();
        do_reset();
        bus.m_read    = 2'b10;
        bus.m_address = 2'b10;
        @(negedge clock);
        bus.m_read = 2'b11;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b01) begin n_fail++; $display("FAIL stag_first_wr got=%b exp=01", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== TS_VAL) begin n_fail++; $display("FAIL stag_first_data got=%h exp=%h", bus.m_readdata, TS_VAL); end
        bus.m_read = 2'b01;
        repeat (3) @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL stag_second_wr got=%b exp=10", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== ID_VAL) begin n_fail++; $display("FAIL stag_second_data got=%h exp=%h", bus.m_readdata, ID_VAL); end
        bus.m_read = 2'b00;
        // Pointer now at 0, so a simultaneous pair must go to master 1
        @(negedge clock);
        bus.m_read = 2'b11;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b01) begin n_fail++; $display("FAIL stag_ptr_wr got=%b exp=01", bus.m_waitrequest); end
        bus.m_read = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m_read    = 2'b01;
        bus.m_address = 2'b01;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rmid_wr got=%b exp=11", bus.m_waitrequest); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rmid_hold_wr got=%b exp=11", bus.m_waitrequest); end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL rmid_addr_wr got=%b exp=11", bus.m_waitrequest); end
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL rmid_done_wr got=%b exp=10", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== TS_VAL) begin n_fail++; $display("FAIL rmid_data got=%h exp=%h", bus.m_readdata, TS_VAL); end
        bus.m_read = 2'b00;
    endtask

    task automatic test_drop_read();
        do_reset();
        bus.m_read    = 2'b01;
        bus.m_address = 2'b10;
        @(negedge clock);
        bus.m_read = 2'b00;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL drop_done_wr got=%b exp=10", bus.m_waitrequest); end
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b11) begin n_fail++; $display("FAIL drop_idle_wr got=%b exp=11", bus.m_waitrequest); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
        bus.m_read = 2'b10;
        repeat (2) @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b01) begin n_fail++; $display("FAIL drop_next_wr got=%b exp=01", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== TS_VAL) begin n_fail++; $display("FAIL drop_next_data got=%h exp=%h", bus.m_readdata, TS_VAL); end
        bus.m_read = 2'b00;
    endtask

    task automatic test_addr_change();
        do_reset();
        // Preload readdata with the timestamp so a stale zero cannot pass
        bus.m_read    = 2'b10;
        bus.m_address = 2'b10;
        repeat (2) @(negedge clock);
        bus.m_read = 2'b00;
        @(negedge clock);
        bus.m_read    = 2'b01;
        bus.m_address = 2'b00;
        @(negedge clock);
        bus.m_address = 2'b01;
        @(negedge clock);
        n_checks++; if (bus.m_waitrequest !== 2'b10) begin n_fail++; $display("FAIL achg_wr got=%b exp=10", bus.m_waitrequest); end
        n_checks++; if (bus.m_readdata !== ID_VAL) begin n_fail++; $display("FAIL achg_data got=%h exp=%h", bus.m_readdata, ID_VAL); end
        bus.m_read = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_staggered();
        test_reset_mid();
        test_drop_read();
        test_addr_change();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
